// File: rtl/ucomb_pkg.sv
// Shared constants and types for the 2-input LUT configuration encoder.
package ucomb_pkg;

    localparam int WORD_W = 31;
    localparam int SEL_W  = 8;

    localparam logic [1:0] SEL_O = 2'd0;
    localparam logic [1:0] SEL_I = 2'd1;
    localparam logic [1:0] SEL_A = 2'd2;
    localparam logic [1:0] SEL_B = 2'd3;

    localparam logic [WORD_W-SEL_W-1:0] PREFIX_DEFAULT = 23'h4C0004;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

endpackage

// File: rtl/ucomb_func_map.sv
// Maps a 2-input truth table to the four 2-bit selector fields {s3,s2,s1,s0}.
module ucomb_func_map
    import ucomb_pkg::*;
(
    input  logic [3:0] func,
    output logic [7:0] sel
);

    always_comb begin
        sel = {SEL_O, SEL_O, SEL_O, SEL_O};
        case (func)
            4'd0:  sel = {SEL_O, SEL_O, SEL_O, SEL_O};
            4'd1:  sel = {SEL_A, SEL_B, SEL_A, SEL_O};
            4'd2:  sel = {SEL_B, SEL_A, SEL_O, SEL_O};
            4'd3:  sel = {SEL_B, SEL_O, SEL_O, SEL_O};
            4'd4:  sel = {SEL_A, SEL_B, SEL_O, SEL_O};
            4'd5:  sel = {SEL_A, SEL_O, SEL_O, SEL_O};
            4'd6:  sel = {SEL_B, SEL_O, SEL_A, SEL_O};
            4'd7:  sel = {SEL_B, SEL_A, SEL_A, SEL_O};
            4'd8:  sel = {SEL_B, SEL_A, SEL_A, SEL_I};
            4'd9:  sel = {SEL_I, SEL_B, SEL_A, SEL_O};
            4'd10: sel = {SEL_I, SEL_A, SEL_O, SEL_O};
            4'd11: sel = {SEL_A, SEL_B, SEL_I, SEL_O};
            4'd12: sel = {SEL_I, SEL_B, SEL_O, SEL_O};
            4'd13: sel = {SEL_B, SEL_A, SEL_I, SEL_O};
            4'd14: sel = {SEL_A, SEL_B, SEL_A, SEL_I};
            4'd15: sel = {SEL_I, SEL_O, SEL_O, SEL_O};
            default: sel = {SEL_O, SEL_O, SEL_O, SEL_O};
        endcase
    end

endmodule

// File: rtl/ucomb_cfg_encoder.sv
// Accepts a truth-table request and shifts the 31-bit configuration word out
// MSB-first, one bit per DIV clocks, followed by a one-cycle latch pulse.
module ucomb_cfg_encoder
    import ucomb_pkg::*;
#(
    parameter int unsigned                DIV    = 1,
    parameter logic [WORD_W-SEL_W-1:0]    PREFIX = PREFIX_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [3:0] req_func,
    output logic       req_ready,
    output logic       cfg_data,
    output logic       cfg_shift,
    output logic       cfg_latch,
    output logic       busy
);

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
    localparam logic [4:0] BIT_LAST = 5'(WORD_W - 1);

    state_t              state_reg, state_next;
    logic [WORD_W-1:0]   shift_reg, shift_next;
    logic [4:0]          bit_cnt_reg, bit_cnt_next;
    logic [7:0]          div_cnt_reg, div_cnt_next;
    logic [SEL_W-1:0]    sel;
    logic                bit_done;

    ucomb_func_map u_func_map (
        .func (req_func),
        .sel  (sel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            div_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            div_cnt_reg <= div_cnt_next;
        end
    end

    assign bit_done = (div_cnt_reg == DIV_LAST);

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        div_cnt_next = div_cnt_reg;
        // Outputs are decoded from registered state only, and held low during reset.
        req_ready    = 1'b0;
        cfg_data     = 1'b0;
        cfg_shift    = 1'b0;
        cfg_latch    = 1'b0;
        busy         = 1'b0;

        case (state_reg)
            IDLE: begin
                req_ready = !rst;
                if (req_valid) begin
                    state_next   = SHIFT;
                    shift_next   = {PREFIX, sel};
                    bit_cnt_next = '0;
                    div_cnt_next = '0;
                end
            end
            SHIFT: begin
                busy      = !rst;
                cfg_data  = !rst && shift_reg[WORD_W-1];
                cfg_shift = !rst && bit_done;
                if (bit_done) begin
                    div_cnt_next = '0;
                    if (bit_cnt_reg == BIT_LAST) begin
                        state_next = LATCH;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 5'd1;
                        shift_next   = {shift_reg[WORD_W-2:0], 1'b0};
                    end
                end else begin
                    div_cnt_next = div_cnt_reg + 8'd1;
                end
            end
            LATCH: begin
                busy       = !rst;
                cfg_latch  = !rst;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ucomb_cfg_encoder.sv
// Directed and randomized bench for ucomb_cfg_encoder with DIV=1 and DIV=3 instances.
module tb_ucomb_cfg_encoder;

    localparam logic [22:0] PREFIX_TB = 23'h4C0004;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid1, valid3;
    logic [3:0] func1, func3;
    logic       ready1, data1, shift1, latch1, busy1;
    logic       ready3, data3, shift3, latch3, busy3;

    int checks = 0;
    int errors = 0;

    // Truth-table rows written as selector symbols s3..s0.
    string tbl [16] = '{"OOOO", "abaO", "baOO", "bOOO", "abOO", "aOOO", "bOaO", "baaO",
                        "baaI", "IbaO", "IaOO", "abIO", "IbOO", "baIO", "abaI", "IOOO"};

    always #5 clk = ~clk;

    ucomb_cfg_encoder #(.DIV(1), .PREFIX(PREFIX_TB)) dut1 (
        .clk(clk), .rst(rst), .req_valid(valid1), .req_func(func1), .req_ready(ready1),
        .cfg_data(data1), .cfg_shift(shift1), .cfg_latch(latch1), .busy(busy1)
    );

    ucomb_cfg_encoder #(.DIV(3), .PREFIX(PREFIX_TB)) dut3 (
        .clk(clk), .rst(rst), .req_valid(valid3), .req_func(func3), .req_ready(ready3),
        .cfg_data(data3), .cfg_shift(shift3), .cfg_latch(latch3), .busy(busy3)
    );

    function automatic logic [1:0] sym_code(input byte c);
        case (c)
            "I":     return 2'd1;
            "a":     return 2'd2;
            "b":     return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [30:0] model_word(input int f);
        string      s = tbl[f];
        logic [7:0] b = '0;
        for (int i = 0; i < 4; i++) b = {b[5:0], sym_code(s[i])};
        return {PREFIX_TB, b};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sends one word on the DIV=1 instance; returns at the negedge of cycle T+33.
    task automatic send1(input logic [3:0] f, input bit hold, input logic [3:0] nxt,
                         output logic [30:0] word, output int nshift, output int latch_k,
                         output int bad);
        int waits = 0;
        while (!ready1 && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        check("ready_before_req", 64'(ready1), 64'd1);
        valid1 = 1'b1;
        func1  = f;
        @(posedge clk);
        word = '0; nshift = 0; latch_k = 0; bad = 0;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (hold) func1 = nxt;
            else begin
                valid1 = 1'b0;
                func1  = 4'($urandom);
            end
            if (shift1) begin
                word = {word[29:0], data1};
                nshift++;
            end
            if (latch1) latch_k = k;
            if (k <= 31 && (!shift1 || !busy1 || ready1 || latch1)) bad++;
            if (k == 32 && (shift1 || data1 || !busy1 || ready1)) bad++;
            if (k == 33 && (shift1 || data1 || latch1 || busy1)) bad++;
        end
        check("ready_after_latch", 64'(ready1), 64'd1);
    endtask

    task automatic check_word(input string tag, input int f, input logic [30:0] word,
                              input int nshift, input int latch_k, input int bad);
        check({tag, "_word"}, 64'(word), 64'(model_word(f)));
        check({tag, "_nshift"}, 64'(nshift), 64'd31);
        check({tag, "_latch_cycle"}, 64'(latch_k), 64'd32);
        check({tag, "_handshake"}, 64'(bad), 64'd0);
    endtask

    initial begin
        logic [30:0] word;
        int          nshift, latch_k, bad, f, cnt;

        rst = 1'b1; valid1 = 1'b0; valid3 = 1'b0; func1 = '0; func3 = '0;
        repeat (3) @(negedge clk);
        check("reset_outs_div1", 64'({ready1, busy1, shift1, latch1, data1}), 64'd0);
        check("reset_outs_div3", 64'({ready3, busy3, shift3, latch3, data3}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'({ready1, ready3}), 64'b11);

        // Known example word for func=1.
        send1(4'd1, 1'b0, 4'd0, word, nshift, latch_k, bad);
        check("func1_literal", 64'(word), 64'h4C0004B8);
        check_word("func1", 1, word, nshift, latch_k, bad);

        for (int i = 0; i < 16; i++) begin
            send1(4'(i), 1'b0, 4'd0, word, nshift, latch_k, bad);
            check($sformatf("sweep_f%0d", i), 64'(word), 64'(model_word(i)));
            check($sformatf("sweep_f%0d_latch", i), 64'(latch_k), 64'd32);
        end

        // Valid held high: second word starts right after one idle cycle.
        send1(4'd2, 1'b1, 4'd3, word, nshift, latch_k, bad);
        check_word("b2b_first", 2, word, nshift, latch_k, bad);
        send1(4'd3, 1'b0, 4'd0, word, nshift, latch_k, bad);
        check_word("b2b_second", 3, word, nshift, latch_k, bad);

        for (int i = 0; i < 12; i++) begin
            f = int'($urandom_range(15));
            send1(4'(f), 1'b0, 4'd0, word, nshift, latch_k, bad);
            check_word($sformatf("rand%0d_f%0d", i, f), f, word, nshift, latch_k, bad);
        end

        // Reset in the middle of a word.
        valid1 = 1'b1; func1 = 4'd9;
        @(posedge clk);
        @(negedge clk);
        valid1 = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_reset_busy", 64'({busy1, shift1}), 64'b11);
        rst = 1'b1;
        @(negedge clk);
        check("midword_reset_outs", 64'({ready1, busy1, shift1, latch1, data1}), 64'd0);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (latch1 || busy1 || !ready1) cnt++;
        end
        check("post_reset_quiet", 64'(cnt), 64'd0);
        send1(4'd12, 1'b0, 4'd0, word, nshift, latch_k, bad);
        check_word("post_reset_f12", 12, word, nshift, latch_k, bad);

        // DIV=3 instance, func=14.
        cnt = 0;
        while (!ready3 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("div3_ready", 64'(ready3), 64'd1);
        valid3 = 1'b1; func3 = 4'd14;
        @(posedge clk);
        word = '0; nshift = 0; latch_k = 0; bad = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            valid3 = 1'b0;
            func3  = 4'($urandom);
            if (shift3) begin
                word = {word[29:0], data3};
                nshift++;
                if (k % 3 != 0) bad++;
            end else if (k % 3 == 0 && k <= 93) begin
                bad++;
            end
            if (latch3 && latch_k == 0) latch_k = k;
        end
        check("div3_word", 64'(word), 64'(model_word(14)));
        check("div3_nshift", 64'(nshift), 64'd31);
        check("div3_shift_spacing", 64'(bad), 64'd0);
        check("div3_latch_cycle", 64'(latch_k), 64'd94);
        check("div3_ready_end", 64'(ready3), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
